// File: rtl/edgcol_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edgcol_pkg
// Description : Shared defaults, fill-state encoding and slice helper for the
//               edge-collision register bank.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package edgcol_pkg;

  localparam int C_REG_WIDTH = 32;
  localparam int C_REG_COUNT = 6;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_t;

  // Bit offset of entry idx inside the flat rdData bus
  function automatic int slice_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edgcol_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : edgcol_fill_ctrl
// Description : Fill FSM for the register bank. Tracks the append pointer,
//               full flag and sticky bad-address error, and produces the
//               one-hot entry write enables and the write-data select.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module edgcol_fill_ctrl
  import edgcol_pkg::*;
#(
  parameter int REG_COUNT  = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_ena,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                  i_app_valid,
  input  logic                  i_clr,
  output logic                  o_app_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_wr_err,
  output logic [REG_COUNT-1:0]  o_wr_sel,
  output logic                  o_app_sel
);

  localparam logic [ADDR_WIDTH:0] c_count_max  = (ADDR_WIDTH+1)'(REG_COUNT);
  localparam logic [ADDR_WIDTH:0] c_count_last = (ADDR_WIDTH+1)'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH:0] c_count_one  = (ADDR_WIDTH+1)'(1);

  fill_state_t         r_state;
  fill_state_t         w_state_nxt;
  logic [ADDR_WIDTH:0] r_count;
  logic [ADDR_WIDTH:0] w_count_nxt;
  logic                r_wr_err;
  logic                w_wr_err_nxt;
  logic                w_addr_ok;
  logic                w_full;
  logic                w_push;

  assign w_addr_ok   = ({1'b0, i_wr_addr} < c_count_max);
  assign w_full      = (r_state == FULL);
  // Random write owns the cycle, so the stream is held off while it is active
  assign o_app_ready = !w_full && !i_wr_ena;
  // A clear in the same cycle drops the transfer
  assign w_push      = i_app_valid && o_app_ready && !i_clr;

  // State, pointer and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= EMPTY;
      r_count  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

  // Next state: clear beats random write beats append
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_wr_err_nxt = r_wr_err;
    if (i_clr) begin
      w_state_nxt  = EMPTY;
      w_count_nxt  = '0;
      w_wr_err_nxt = 1'b0;
    end else if (i_wr_ena) begin
      if (!w_addr_ok) begin
        w_wr_err_nxt = 1'b1;
      end
    end else if (w_push) begin
      w_count_nxt = r_count + c_count_one;
      case (r_state)
        EMPTY:   w_state_nxt = (REG_COUNT == 1) ? FULL : FILLING;
        FILLING: if (r_count == c_count_last) w_state_nxt = FULL;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // One-hot entry enable: random address or append pointer
  always_comb begin
    o_wr_sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (!i_clr && i_wr_ena && w_addr_ok) begin
        o_wr_sel[i] = (i_wr_addr == ADDR_WIDTH'(i));
      end else if (w_push) begin
        o_wr_sel[i] = (r_count == (ADDR_WIDTH+1)'(i));
      end
    end
  end

  assign o_app_sel = !i_wr_ena;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_wr_err  = r_wr_err;

endmodule
`default_nettype wire

// File: rtl/edgcol_reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : edgcol_reg_cell
// Description : Single storage entry with write enable; clears on reset.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module edgcol_reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Entry storage: cleared by reset, loaded when selected
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_wr_en) begin
      r_q <= i_wr_data;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/edgcol_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : edgcol_reg_bank
// Description : REG_COUNT x REG_WIDTH register bank, all entries visible in
//               parallel. Random-access write port plus in-order append
//               stream, with per-entry valid mask and fill tracking.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module edgcol_reg_bank
  import edgcol_pkg::*;
#(
  parameter int REG_WIDTH  = C_REG_WIDTH,
  parameter int REG_COUNT  = C_REG_COUNT,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wrEna,
  input  logic [ADDR_WIDTH-1:0]          wrAddr,
  input  logic [REG_WIDTH-1:0]           wrData,
  input  logic                           appValid,
  input  logic [REG_WIDTH-1:0]           appData,
  output logic                           appReady,
  input  logic                           clr,
  output logic [REG_COUNT*REG_WIDTH-1:0] rdData,
  output logic [REG_COUNT-1:0]           validMask,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           full,
  output logic                           wrErr
);

  if (ADDR_WIDTH != $clog2(REG_COUNT) || REG_COUNT < 2 || REG_COUNT > 64) begin : g_param_check
    $error("edgcol_reg_bank: REG_COUNT must be 2..64 and ADDR_WIDTH == clog2(REG_COUNT)");
  end

  logic [REG_COUNT-1:0] w_wr_sel;
  logic                 w_app_sel;
  logic [REG_WIDTH-1:0] w_wr_data;
  logic [REG_COUNT-1:0] r_valid_mask;

  edgcol_fill_ctrl #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_wr_ena    (wrEna),
    .i_wr_addr   (wrAddr),
    .i_app_valid (appValid),
    .i_clr       (clr),
    .o_app_ready (appReady),
    .o_count     (count),
    .o_full      (full),
    .o_wr_err    (wrErr),
    .o_wr_sel    (w_wr_sel),
    .o_app_sel   (w_app_sel)
  );

  assign w_wr_data = w_app_sel ? appData : wrData;

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_entry
    localparam int c_off = slice_off(gi, REG_WIDTH);
    edgcol_reg_cell #(
      .WIDTH (REG_WIDTH)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_sel[gi]),
      .i_wr_data (w_wr_data),
      .o_q       (rdData[c_off +: REG_WIDTH])
    );
  end

  // Valid mask: set by any entry write, cleared by clr or reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid_mask <= '0;
    end else if (clr) begin
      r_valid_mask <= '0;
    end else begin
      r_valid_mask <= r_valid_mask | w_wr_sel;
    end
  end

  assign validMask = r_valid_mask;

endmodule
`default_nettype wire

// File: tb/tb_edgcol_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_edgcol_reg_bank
// Description : Scoreboard bench for edgcol_reg_bank with directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edgcol_reg_bank;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEna;
  logic [AW-1:0] wrAddr;
  logic [W-1:0]  wrData;
  logic          appValid;
  logic [W-1:0]  appData;
  logic          appReady;
  logic          clr;
  logic [BW-1:0] rdData;
  logic [N-1:0]  validMask;
  logic [AW:0]   count;
  logic          full;
  logic          wrErr;

  always #5 clk = ~clk;

  edgcol_reg_bank #(
    .REG_WIDTH  (W),
    .REG_COUNT  (N),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wrEna     (wrEna),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .appValid  (appValid),
    .appData   (appData),
    .appReady  (appReady),
    .clr       (clr),
    .rdData    (rdData),
    .validMask (validMask),
    .count     (count),
    .full      (full),
    .wrErr     (wrErr)
  );

  typedef struct {
    logic [BW-1:0] rd;
    logic [N-1:0]  mask;
    logic [AW:0]   cnt;
    logic          full;
    logic          err;
    logic          ready;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model: array of entries, valid flags, append count, error flag
  logic [W-1:0] m_ent [N];
  bit           m_val [N];
  int           m_cnt;
  bit           m_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ent[i] = '0;
      m_val[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  function automatic exp_t snapshot(input bit ready);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.rd[i*W +: W] = m_ent[i];
      e.mask[i]      = m_val[i];
    end
    e.cnt   = m_cnt[AW:0];
    e.full  = (m_cnt == N);
    e.err   = m_err;
    e.ready = ready;
    return e;
  endfunction

  // One clock of stimulus; expected outputs for this cycle go to the scoreboard
  task automatic step(input bit rn, input bit we, input int addr, input logic [W-1:0] wd,
                      input bit av, input logic [W-1:0] ad, input bit cl, output bit took);
    bit ready;
    @(posedge clk);
    #1;
    rst      = rn;
    wrEna    = we;
    wrAddr   = addr[AW-1:0];
    wrData   = wd;
    appValid = av;
    appData  = ad;
    clr      = cl;
    ready = (m_cnt != N) && !we;
    sb_q.push_back(snapshot(ready));
    took = 1'b0;
    if (!rn) begin
      model_reset();
    end else if (cl) begin
      for (int i = 0; i < N; i++) m_val[i] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end else if (we) begin
      if (addr < N) begin
        m_ent[addr] = wd;
        m_val[addr] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end else if (av && ready) begin
      m_ent[m_cnt] = ad;
      m_val[m_cnt] = 1'b1;
      m_cnt++;
      took = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b0, t);
  endtask

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rdData",    rdData,         e.rd);
        check("validMask", BW'(validMask), BW'(e.mask));
        check("count",     BW'(count),     BW'(e.cnt));
        check("full",      BW'(full),      BW'(e.full));
        check("wrErr",     BW'(wrErr),     BW'(e.err));
        check("appReady",  BW'(appReady),  BW'(e.ready));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           t;
    bit           stall;
    bit           rn, cl, we, av;
    int           addr;
    logic [W-1:0] pd;

    rst = 1'b0; wrEna = 1'b0; wrAddr = '0; wrData = '0;
    appValid = 1'b0; appData = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state observed, then release
    idle(2);

    // Append fill: seven offers, only six fit
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 0, '0, 1'b1, W'(10 + k), 1'b0, t);
    idle(1);

    // Collision of write paths at count 0
    step(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, t);
    step(1'b1, 1'b1, 2, W'(99), 1'b1, W'(5), 1'b0, t);
    step(1'b1, 1'b0, 0, '0, 1'b1, W'(5), 1'b0, t);
    idle(1);

    // Bad address, sticky error, then clear
    step(1'b1, 1'b1, 7, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, t);
    idle(2);
    step(1'b1, 1'b0, 0, '0, 1'b0, '0, 1'b1, t);
    idle(1);

    // Fill to full, then clear together with write and append
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 0, '0, 1'b1, W'(100 + k), 1'b0, t);
    idle(1);
    step(1'b1, 1'b1, 3, W'(77), 1'b1, W'(55), 1'b1, t);
    idle(1);

    // Reset mid-fill, then append lands in entry 0
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, '0, 1'b1, W'(200 + k), 1'b0, t);
    step(1'b0, 1'b0, 0, '0, 1'b0, '0, 1'b0, t);
    step(1'b1, 1'b0, 0, '0, 1'b1, 32'h0000_0ABC, 1'b0, t);
    idle(1);

    // Randomized traffic; held append data while stalled
    stall = 1'b0;
    pd    = '0;
    for (int k = 0; k < 400; k++) begin
      rn   = ($urandom_range(0, 99) >= 2);
      cl   = ($urandom_range(0, 99) < 5);
      we   = ($urandom_range(0, 99) < 25);
      addr = $urandom_range(0, 7);
      av   = stall ? 1'b1 : ($urandom_range(0, 99) < 60);
      if (!stall) pd = $urandom;
      step(rn, we, addr, $urandom, av, pd, cl, t);
      stall = av && !t;
    end
    idle(1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
